// File: rtl/acc_core_pkg.sv
// acc_core_pkg
// Shared constants for the parametrised accumulator core.
//   - OP_* : 8-bit opcode values; the core zero-extends them to the data
//            width so an opcode word matches only when every upper bit is 0.
//   - ST_* : two-bit FSM state encoding used by acc_core_param.
// No ports (package).
package acc_core_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_ADD  = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03;
   localparam logic [7:0] OP_AND  = 8'h04;
   localparam logic [7:0] OP_OR   = 8'h05;
   localparam logic [7:0] OP_XOR  = 8'h06;
   localparam logic [7:0] OP_NOT  = 8'h07;
   localparam logic [7:0] OP_SHL  = 8'h08;
   localparam logic [7:0] OP_SHR  = 8'h09;
   localparam logic [7:0] OP_HALT = 8'h0A;
   localparam logic [7:0] OP_ADC  = 8'h0B;
   localparam logic [7:0] OP_LD   = 8'h0C;
   localparam logic [7:0] OP_ST   = 8'h0D;
   localparam logic [7:0] OP_JMP  = 8'h0E;
   localparam logic [7:0] OP_JZ   = 8'h0F;
   localparam logic [7:0] OP_JC   = 8'h10;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_HALT   = 2'd3;

endpackage

// File: rtl/acc_core_alu.sv
// acc_core_alu
// Combinational datapath of the accumulator core.
// Ports:
//   op       in  DW  opcode word (compared over the full width)
//   ac       in  DW  current accumulator
//   operand  in  DW  second operand; for LD the top supplies the loaded word
//   c_in     in  1   current carry flag
//   result   out DW  new accumulator value
//   c_out    out 1   new carry value
//   we_acc   out 1   instruction writes the accumulator (and so Z)
//   upd_c    out 1   instruction writes the carry flag
module acc_core_alu
   import acc_core_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [DW-1:0] op,
   input  logic [DW-1:0] ac,
   input  logic [DW-1:0] operand,
   input  logic          c_in,
   output logic [DW-1:0] result,
   output logic          c_out,
   output logic          we_acc,
   output logic          upd_c
);

   logic [DW:0] sum;

   // Decode the opcode and compute the new accumulator and carry. LD is
   // handled like LDI because the top has already muxed the memory word
   // onto the operand input.
   always_comb begin
      result = ac;
      c_out  = c_in;
      we_acc = 1'b0;
      upd_c  = 1'b0;
      sum    = '0;
      case (op)
         DW'(OP_LDI), DW'(OP_LD): begin
            result = operand;
            we_acc = 1'b1;
         end
         DW'(OP_ADD): begin
            sum    = {1'b0, ac} + {1'b0, operand};
            result = sum[DW-1:0];
            c_out  = sum[DW];
            we_acc = 1'b1;
            upd_c  = 1'b1;
         end
         DW'(OP_ADC): begin
            sum    = {1'b0, ac} + {1'b0, operand} + {{DW{1'b0}}, c_in};
            result = sum[DW-1:0];
            c_out  = sum[DW];
            we_acc = 1'b1;
            upd_c  = 1'b1;
         end
         DW'(OP_SUB): begin
            result = ac - operand;
            c_out  = (ac < operand);
            we_acc = 1'b1;
            upd_c  = 1'b1;
         end
         DW'(OP_AND): begin
            result = ac & operand;
            we_acc = 1'b1;
         end
         DW'(OP_OR): begin
            result = ac | operand;
            we_acc = 1'b1;
         end
         DW'(OP_XOR): begin
            result = ac ^ operand;
            we_acc = 1'b1;
         end
         DW'(OP_NOT): begin
            result = ~ac;
            we_acc = 1'b1;
         end
         DW'(OP_SHL): begin
            result = {ac[DW-2:0], 1'b0};
            c_out  = ac[DW-1];
            we_acc = 1'b1;
            upd_c  = 1'b1;
         end
         DW'(OP_SHR): begin
            result = {1'b0, ac[DW-1:1]};
            c_out  = ac[0];
            we_acc = 1'b1;
            upd_c  = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/acc_core_param.sv
// acc_core_param
// Parametrised two-word-instruction accumulator machine with a unified
// program/data memory, Z/C flags, run/restart control and optional
// conditional branching (enabled by defining ACC_CORE_BRANCH_EN; without it
// opcodes 0E/0F/10 are undefined and halt the core with illegal set).
// Parameters: DW data/instruction width (>= 8), AW address width.
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   synchronous active-low reset (memory is kept)
//   prog_we    in   1   program-write strobe, holds the core
//   prog_addr  in   AW  program-write address
//   prog_data  in   DW  program-write data
//   run        in   1   execution enable
//   restart    in   1   pulse: PC, AC, flags cleared, back to FETCH
//   acc        out  DW  accumulator
//   pc         out  AW  program counter
//   flag_z     out  1   zero flag
//   flag_c     out  1   carry/borrow flag
//   halted     out  1   core sits in HALT
//   illegal    out  1   sticky, halted on an undefined opcode
module acc_core_param
   import acc_core_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_data,
   input  logic          run,
   input  logic          restart,
   output logic [DW-1:0] acc,
   output logic [AW-1:0] pc,
   output logic          flag_z,
   output logic          flag_c,
   output logic          halted,
   output logic          illegal
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [1:0]    state;
   logic [DW-1:0] opcode_q;
   logic [DW-1:0] operand_q;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_result;
   logic          alu_c_out;
   logic          alu_we_acc;
   logic          alu_upd_c;
   logic          opcode_valid;
   logic          branch_taken;
   logic          st_fire;

   // LD reuses the ALU's load path; the memory word replaces the operand.
   // The read is combinational, so a word stored by the previous
   // instruction is already visible here.
   assign alu_b = (opcode_q == DW'(OP_LD)) ? mem[operand_q[AW-1:0]] : operand_q;

   acc_core_alu #(.DW(DW)) u_alu (
      .op      (opcode_q),
      .ac      (acc),
      .operand (alu_b),
      .c_in    (flag_c),
      .result  (alu_result),
      .c_out   (alu_c_out),
      .we_acc  (alu_we_acc),
      .upd_c   (alu_upd_c)
   );

   // Every defined opcode; anything else sends the core to HALT with
   // illegal set. Branch opcodes are defined only when branching is built in.
   always_comb begin
      opcode_valid = 1'b0;
      case (opcode_q)
         DW'(OP_NOP), DW'(OP_LDI), DW'(OP_ADD), DW'(OP_SUB),
         DW'(OP_AND), DW'(OP_OR),  DW'(OP_XOR), DW'(OP_NOT),
         DW'(OP_SHL), DW'(OP_SHR), DW'(OP_HALT), DW'(OP_ADC),
         DW'(OP_LD),  DW'(OP_ST):
            opcode_valid = 1'b1;
`ifdef ACC_CORE_BRANCH_EN
         DW'(OP_JMP), DW'(OP_JZ), DW'(OP_JC):
            opcode_valid = 1'b1;
`endif
         default:
            opcode_valid = 1'b0;
      endcase
   end

`ifdef ACC_CORE_BRANCH_EN
   // Branch condition uses the flags as they stand before this instruction.
   assign branch_taken = (opcode_q == DW'(OP_JMP)) ||
                         ((opcode_q == DW'(OP_JZ)) && flag_z) ||
                         ((opcode_q == DW'(OP_JC)) && flag_c);
`else
   assign branch_taken = 1'b0;
`endif

   // A store commits only on a genuine run-enabled EXECUTE edge; reset,
   // restart or a program write on that edge cancels it.
   assign st_fire = rst_n && !restart && !prog_we && run &&
                    (state == ST_EXEC) && (opcode_q == DW'(OP_ST));

   assign halted = (state == ST_HALT);

   // Memory has no reset so programs survive reset and restart. A program
   // write still happens alongside restart, but not while rst_n is low.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (prog_we) begin
            mem[prog_addr] <= prog_data;
         end else if (st_fire) begin
            mem[operand_q[AW-1:0]] <= acc;
         end
      end
   end

   // Core FSM, PC, accumulator and flags. Priority is reset, restart,
   // program write (hold), then run. PC arithmetic wraps at AW bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_FETCH;
         pc        <= '0;
         acc       <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         illegal   <= 1'b0;
         opcode_q  <= '0;
         operand_q <= '0;
      end else if (restart) begin
         state   <= ST_FETCH;
         pc      <= '0;
         acc     <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         illegal <= 1'b0;
      end else if (!prog_we && run) begin
         case (state)
            ST_FETCH: begin
               opcode_q <= mem[pc];
               pc       <= pc + AW'(1);
               state    <= ST_DECODE;
            end
            ST_DECODE: begin
               operand_q <= mem[pc];
               pc        <= pc + AW'(1);
               state     <= ST_EXEC;
            end
            ST_EXEC: begin
               if (!opcode_valid) begin
                  state   <= ST_HALT;
                  illegal <= 1'b1;
               end else if (opcode_q == DW'(OP_HALT)) begin
                  state <= ST_HALT;
               end else begin
                  state <= ST_FETCH;
                  if (alu_we_acc) begin
                     acc    <= alu_result;
                     flag_z <= (alu_result == '0);
                  end
                  if (alu_upd_c) begin
                     flag_c <= alu_c_out;
                  end
`ifdef ACC_CORE_BRANCH_EN
                  if (branch_taken) begin
                     pc <= operand_q[AW-1:0];
                  end
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_core_param.sv
// tb_acc_core_param
// Directed bench for acc_core_param (DW=8, AW=5). Expected states are
// queued before each stimulus step and popped when the step completes.
module tb_acc_core_param;

   localparam int DW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic          run;
   logic          restart;
   logic [DW-1:0] acc;
   logic [AW-1:0] pc;
   logic          flag_z;
   logic          flag_c;
   logic          halted;
   logic          illegal;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [7:0] acc;
      logic [4:0] pc;
      logic       z;
      logic       c;
      logic       halted;
      logic       illegal;
   } exp_t;

   exp_t       sb[$];
   string      tag_q[$];
   logic [7:0] prog[$];

   // Free-running clock; inputs change and outputs are sampled on negedge.
   always #5 clk = ~clk;

   acc_core_param #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .run       (run),
      .restart   (restart),
      .acc       (acc),
      .pc        (pc),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .halted    (halted),
      .illegal   (illegal)
   );

   // One comparison: counts it, and on a miss counts the failure and reports.
   task automatic checkField(input string tag, input string field,
                             input logic [7:0] obs, input logic [7:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         tests_failed++;
         $error("[TB] FAIL %s/%s observed=%h expected=%h", tag, field, obs, exp_v);
      end
   endtask

   // Queue the state the DUT should show after the next stimulus step.
   task automatic expectState(input string tag, input logic [7:0] a, input logic [4:0] p,
                              input logic z, input logic c, input logic h, input logic il);
      exp_t e;
      e.acc = a; e.pc = p; e.z = z; e.c = c; e.halted = h; e.illegal = il;
      sb.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Pop the oldest expectation and compare every observable output.
   task automatic checkOutput();
      exp_t  e;
      string t;
      e = sb.pop_front();
      t = tag_q.pop_front();
      checkField(t, "acc",     acc,               e.acc);
      checkField(t, "pc",      {3'b000, pc},      {3'b000, e.pc});
      checkField(t, "flag_z",  {7'b0, flag_z},    {7'b0, e.z});
      checkField(t, "flag_c",  {7'b0, flag_c},    {7'b0, e.c});
      checkField(t, "halted",  {7'b0, halted},    {7'b0, e.halted});
      checkField(t, "illegal", {7'b0, illegal},   {7'b0, e.illegal});
   endtask

   // Hold run at run_v for a number of clock edges, then drop it.
   task automatic applyStimulus(input int cycles, input logic run_v);
      run = run_v;
      repeat (cycles) @(negedge clk);
      run = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic loadByte(input logic [4:0] addr, input logic [7:0] data);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   task automatic loadProg();
      for (int i = 0; i < prog.size(); i++) begin
         loadByte(5'(i), prog[i]);
      end
   endtask

   task automatic pulseRestart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      run       = 1'b0;
      restart   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      expectState("reset", 8'h00, 5'd0, 0, 0, 0, 0);
      checkOutput();

      // LDI 5; ADD 3; HALT -> halts exactly at cycle 9
      prog = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h0A, 8'h00};
      loadProg();
      expectState("p1_cycle8", 8'h08, 5'd6, 0, 0, 0, 0);
      applyStimulus(8, 1'b1);
      checkOutput();
      expectState("p1_cycle9", 8'h08, 5'd6, 0, 0, 1, 0);
      applyStimulus(1, 1'b1);
      checkOutput();

      // ADD carry-out to zero, then ADC consumes the carry
      doReset();
      prog = '{8'h01, 8'hFF, 8'h02, 8'h01, 8'h0B, 8'h00, 8'h0A, 8'h00};
      loadProg();
      expectState("add_wrap", 8'h00, 5'd4, 1, 1, 0, 0);
      applyStimulus(6, 1'b1);
      checkOutput();
      expectState("adc", 8'h01, 5'd6, 0, 0, 0, 0);
      applyStimulus(3, 1'b1);
      checkOutput();
      expectState("p2_halt", 8'h01, 5'd8, 0, 0, 1, 0);
      applyStimulus(3, 1'b1);
      checkOutput();

      // SUB borrow, then SHR shifts out a 0
      doReset();
      prog = '{8'h01, 8'h03, 8'h03, 8'h05, 8'h09, 8'h00, 8'h0A, 8'h00};
      loadProg();
      expectState("sub_borrow", 8'hFE, 5'd4, 0, 1, 0, 0);
      applyStimulus(6, 1'b1);
      checkOutput();
      expectState("shr", 8'h7F, 5'd6, 0, 0, 0, 0);
      applyStimulus(3, 1'b1);
      checkOutput();

      // ST then LD of the same address; memory survives reset
      doReset();
      prog = '{8'h01, 8'hAA, 8'h0D, 8'h1E, 8'h01, 8'h00, 8'h0C, 8'h1E, 8'h0A, 8'h00};
      loadProg();
      expectState("st_ld", 8'hAA, 5'd10, 0, 0, 1, 0);
      applyStimulus(15, 1'b1);
      checkOutput();
      doReset();
      expectState("reset_after_halt", 8'h00, 5'd0, 0, 0, 0, 0);
      checkOutput();
      prog = '{8'h0C, 8'h1E, 8'h0A, 8'h00};
      loadProg();
      expectState("ld_after_reset", 8'hAA, 5'd4, 0, 0, 1, 0);
      applyStimulus(6, 1'b1);
      checkOutput();

      // Countdown loop: branches, or an illegal halt when branching is absent
      doReset();
      prog = '{8'h01, 8'h03, 8'h03, 8'h01, 8'h0F, 8'h08, 8'h0E, 8'h02, 8'h0A, 8'h00};
      loadProg();
`ifdef ACC_CORE_BRANCH_EN
      expectState("loop_first_jz", 8'h02, 5'd6, 0, 0, 0, 0);
      applyStimulus(9, 1'b1);
      checkOutput();
      expectState("loop_done", 8'h00, 5'd10, 1, 0, 1, 0);
      applyStimulus(21, 1'b1);
      checkOutput();
`else
      expectState("loop_illegal", 8'h02, 5'd6, 0, 0, 1, 1);
      applyStimulus(9, 1'b1);
      checkOutput();
      expectState("illegal_holds", 8'h02, 5'd6, 0, 0, 1, 1);
      applyStimulus(21, 1'b1);
      checkOutput();
`endif

      // Undefined opcode halts with illegal set
      doReset();
      prog = '{8'h11, 8'h00};
      loadProg();
      expectState("undef_op", 8'h00, 5'd2, 0, 0, 1, 1);
      applyStimulus(3, 1'b1);
      checkOutput();

      // run=0 freezes mid-program; restart reruns to the same result
      doReset();
      prog = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h0A, 8'h00};
      loadProg();
      expectState("pre_hold", 8'h05, 5'd3, 0, 0, 0, 0);
      applyStimulus(4, 1'b1);
      checkOutput();
      expectState("hold", 8'h05, 5'd3, 0, 0, 0, 0);
      applyStimulus(10, 1'b0);
      checkOutput();
      expectState("after_hold", 8'h08, 5'd6, 0, 0, 1, 0);
      applyStimulus(5, 1'b1);
      checkOutput();
      pulseRestart();
      expectState("restart", 8'h00, 5'd0, 0, 0, 0, 0);
      checkOutput();
      expectState("rerun", 8'h08, 5'd6, 0, 0, 1, 0);
      applyStimulus(9, 1'b1);
      checkOutput();

      // Reset during EXECUTE of ST aborts the store
      doReset();
      prog = '{8'h01, 8'h55, 8'h0D, 8'h1D, 8'h0A, 8'h00};
      loadProg();
      loadByte(5'h1D, 8'h11);
      expectState("pre_abort", 8'h55, 5'd4, 0, 0, 0, 0);
      applyStimulus(5, 1'b1);
      checkOutput();
      run   = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b0;
      expectState("abort_reset", 8'h00, 5'd0, 0, 0, 0, 0);
      checkOutput();
      prog = '{8'h0C, 8'h1D, 8'h0A, 8'h00};
      loadProg();
      expectState("abort_no_st", 8'h11, 5'd4, 0, 0, 1, 0);
      applyStimulus(6, 1'b1);
      checkOutput();

      // restart with prog_we: restart applies and the write still lands
      restart   = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 5'h1C;
      prog_data = 8'h77;
      @(negedge clk);
      restart = 1'b0;
      prog_we = 1'b0;
      expectState("restart_we", 8'h00, 5'd0, 0, 0, 0, 0);
      checkOutput();
      prog = '{8'h0C, 8'h1C, 8'h0A, 8'h00};
      loadProg();
      expectState("restart_we_data", 8'h77, 5'd4, 0, 0, 1, 0);
      applyStimulus(6, 1'b1);
      checkOutput();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/acc_core_param.md
# acc_core_param

Parametrised accumulator core: a generalised successor of the 8-bit two-word-instruction accumulator machine. It adds configurable data width and memory depth, Z/C flags, data load/store to the unified memory, carry-chained add, run/restart control and conditional branching. It sits below the Tiny Tapeout top wrapper, which maps pins onto its program-load and status ports.

## Interface
- `DW`, 8: data/instruction word width; must be ≥ 8
- `AW`, 5: memory address width; depth = 2**AW words
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `prog_we`  in  1  program-write strobe; pauses execution
- `prog_addr`  in  AW  program-write address
- `prog_data`  in  DW  program-write data
- `run`  in  1  execution enable; 0 freezes state, PC and AC
- `restart`  in  1  one-cycle pulse; PC, AC, flags ← 0, state ← FETCH; memory kept
- `acc`  out  DW  accumulator
- `pc`  out  AW  program counter
- `flag_z`, `flag_c`  out  1  zero and carry flags
- `halted`  out  1  core in HALT
- `illegal`  out  1  sticky: halted on an undefined opcode

## Operation
- Instruction = opcode word at PC, operand word at PC+1. The opcode is compared over the full DW width.
- States:
  - FETCH: opcode ← mem[PC], PC+1 → DECODE
  - DECODE: operand ← mem[PC], PC+1 → EXECUTE
  - EXECUTE: perform the op, → FETCH (or HALT)
  - HALT: hold
- Opcodes (`op` = operand):
  - 00 NOP
  - 01 LDI: AC ← op
  - 02 ADD, 03 SUB, 0B ADC (AC+op+C)
  - 04 AND, 05 OR, 06 XOR, 07 NOT
  - 08 SHL, 09 SHR
  - 0A HALT
  - 0C LD: AC ← mem[op[AW-1:0]]
  - 0D ST: mem[op[AW-1:0]] ← AC
  - 0E JMP, 0F JZ, 10 JC: PC ← op[AW-1:0], unconditional or taken when Z / C = 1
- Arithmetic is modulo 2**DW.
  - C = carry-out for ADD/ADC; borrow (AC < op) for SUB.
  - C = bit shifted out for SHL/SHR.
  - Logic ops, NOT and LD leave C unchanged.
- Z = (new AC == 0) after every op that writes AC. Other ops leave the flags unchanged.
- Undefined opcode → HALT with `illegal` = 1.
- PC wraps modulo 2**AW, including an operand fetch at the last address.
- Priority, highest first: `rst_n` low > `restart` > `prog_we` > `run`.
  - When `prog_we` = 1, the memory write happens and the core holds.
  - When `run` = 0, the core holds.
- HALT is left only by reset or `restart`.
- Memory is not cleared by reset.

## Timing
- Reset (synchronous, `rst_n` low at a clk edge): `acc` = 0, `pc` = 0, `flag_z` = 0, `flag_c` = 0, `halted` = 0, `illegal` = 0, state = FETCH.
- Every instruction takes 3 run-enabled cycles. The effect is visible on the outputs the cycle after EXECUTE.
- A taken branch costs nothing extra; the next FETCH uses the target.
- Memory reads are combinational from the register array.
  - ST writes at the EXECUTE edge.
  - An LD of an address written by ST in the previous instruction returns the new value.
- A program write to the current PC takes effect at the next fetch of that address.
- `restart` asserted together with `prog_we`: restart applies, the memory write also occurs.
- Reset asserted mid-instruction aborts it. A pending ST does not write.

## Configuration
- `ACC_CORE_BRANCH_EN` defined: opcodes 0E/0F/10 perform the branches described above.
- Not defined: 0E/0F/10 decode as undefined opcodes (HALT, `illegal` = 1), and the branch-target mux is removed.

## Structure
- Package `acc_core_pkg`:
  - opcode localparams `OP_NOP`…`OP_JC`
  - state encoding `ST_FETCH`, `ST_DECODE`, `ST_EXEC`, `ST_HALT`
- Sub-module `acc_core_alu`: combinational, takes (op, AC, operand, C) and returns (result, C_out, we_acc, upd_c).
- The top holds the FSM, PC, flags and memory.

## Test plan
- DW=8, AW=5. Load `01 05 02 03 0A 00`, run → `acc` = 0x08, `halted` = 1 at cycle 9, `pc` = 6.
- `01 FF 02 01` → `acc` = 0x00, `flag_z` = 1, `flag_c` = 1. Then `0B 00` → `acc` = 0x01, Z = 0, C = 0.
- `01 03 03 05` → `acc` = 0xFE, C = 1 (borrow). SHR → `acc` = 0x7F, C = 0.
- ST/LD:
  - `01 AA 0D 1E 01 00 0C 1E 0A 00` → `acc` = 0xAA.
  - mem[0x1E] = 0xAA, readable via LD after reset.
- Branch (macro on): countdown loop `01 03 03 01 0F 08 0E 02 0A 00` halts with `acc` = 0 after 3 iterations.
  - Macro off: the same program halts with `illegal` = 1 at `pc` = 6.
- Hold and abort:
  - `run` = 0 mid-program freezes `pc` and `acc` for 10 cycles.
  - `restart` pulse → `pc` = 0, `acc` = 0, the program reruns to the same result.
  - `rst_n` low during EXECUTE of ST leaves memory unchanged.
